// File: rtl/cpu_pkg.sv
// Shared CPU types: memory access widths, load/store controller states, opcodes.
// Pure declarations, no logic.
package cpu_pkg;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_funct3_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    typedef enum logic [6:0] {
        OP_LW = 7'b0000011,
        OP_SW = 7'b0100011
    } opcode_t;

endpackage

// File: rtl/load_store_align.sv
// Combinational byte-lane steering: store merge, load extension and misalign/funct3 faults.
// Zero latency; no flow control of its own.
module load_store_align
    import cpu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic        write,
    input  logic [1:0]  lane,
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    output logic [31:0] store_word,
    output logic [31:0] load_data,
    output logic        error
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic        bad_funct3;
    logic        misaligned;

    assign sel_byte = old_word[{lane, 3'b000} +: 8];
    assign sel_half = lane[1] ? old_word[31:16] : old_word[15:0];

    always_comb begin
        load_data = 32'h0;
        case (mem_funct3_t'(funct3))
            MEM_B:   load_data = {{24{sel_byte[7]}}, sel_byte};
            MEM_H:   load_data = {{16{sel_half[15]}}, sel_half};
            MEM_W:   load_data = old_word;
            MEM_BU:  load_data = {24'h0, sel_byte};
            MEM_HU:  load_data = {16'h0, sel_half};
            default: load_data = 32'h0;
        endcase
    end

    always_comb begin
        store_word = old_word;
        case (mem_funct3_t'(funct3))
            MEM_B:   store_word[{lane, 3'b000} +: 8] = wdata[7:0];
            MEM_H:   store_word[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            MEM_W:   store_word = wdata;
            default: store_word = old_word;
        endcase
    end

    // Stores only know B/H/W; loads additionally accept the unsigned variants.
    always_comb begin
        if (write)
            bad_funct3 = (funct3[2] == 1'b1) || (funct3[1:0] == 2'b11);
        else
            bad_funct3 = (funct3[1:0] == 2'b11) || (funct3 == 3'b110);
    end

    always_comb begin
        misaligned = 1'b0;
        if (funct3[1:0] == 2'b01)
            misaligned = lane[0];
        else if (funct3 == 3'b010)
            misaligned = (lane != 2'b00);
    end

    assign error = bad_funct3 | misaligned;

endmodule

// File: rtl/data_memory_ctrl.sv
// Handshaked RV32I load/store unit over a DEPTH-word array, one outstanding request.
// Response READ_LATENCY edges after acceptance; holds response until resp_ready, req_ready low meanwhile.
module data_memory_ctrl
    import cpu_pkg::*;
#(
    parameter int DEPTH        = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [2:0]             req_funct3,
    input  logic [31:0]            req_addr,
    input  logic [31:0]            req_wdata,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [31:0]            resp_rdata,
    output logic                   resp_error,
    input  logic [DEPTH-1:0][31:0] initial_values,
    output logic [DEPTH-1:0][31:0] memory_check
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [1:0] CNT_INIT = 2'(READ_LATENCY - 2);

    mem_state_t state_q, state_d;
    logic [1:0] cnt_q, cnt_d;

    logic        lat_write;
    logic [2:0]  lat_funct3;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;

    logic [DEPTH-1:0][31:0] mem;

    logic        cur_write;
    logic [2:0]  cur_funct3;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic [AW-1:0] idx;
    logic        range_err;
    logic        align_err;
    logic        access_err;
    logic        enter_resp;
    logic [31:0] store_word;
    logic [31:0] load_data;

    // With single-cycle latency the array is touched on the accepting edge, before the latch fills.
    assign cur_write  = (state_q == IDLE) ? req_write  : lat_write;
    assign cur_funct3 = (state_q == IDLE) ? req_funct3 : lat_funct3;
    assign cur_addr   = (state_q == IDLE) ? req_addr   : lat_addr;
    assign cur_wdata  = (state_q == IDLE) ? req_wdata  : lat_wdata;

    assign idx        = cur_addr[AW+1:2];
    assign range_err  = |cur_addr[31:AW+2];
    assign access_err = range_err | align_err;
    assign enter_resp = (state_d == RESP) && (state_q != RESP);

    load_store_align u_align (
        .funct3     (cur_funct3),
        .write      (cur_write),
        .lane       (cur_addr[1:0]),
        .old_word   (mem[idx]),
        .wdata      (cur_wdata),
        .store_word (store_word),
        .load_data  (load_data),
        .error      (align_err)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (READ_LATENCY == 1) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 2'd0)
                    state_d = RESP;
                else
                    cnt_d = 2'(cnt_q - 2'd1);
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lat_write  <= 1'b0;
            lat_funct3 <= 3'b000;
            lat_addr   <= 32'h0;
            lat_wdata  <= 32'h0;
        end else if (state_q == IDLE && req_valid) begin
            lat_write  <= req_write;
            lat_funct3 <= req_funct3;
            lat_addr   <= req_addr;
            lat_wdata  <= req_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp_rdata <= 32'h0;
            resp_error <= 1'b0;
        end else if (enter_resp) begin
            resp_error <= access_err;
            resp_rdata <= (access_err || cur_write) ? 32'h0 : load_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            mem <= initial_values;
        else if (enter_resp && cur_write && !access_err)
            mem[idx] <= store_word;
    end

    assign memory_check = mem;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench: one controller at READ_LATENCY=1 (index 0) and one at READ_LATENCY=3 (index 1).
module tb_data_memory_ctrl;

    localparam int DEPTH = 32;

    logic clk;
    logic reset;
    logic [DEPTH-1:0][31:0] init_vals;

    logic        rq_valid [2];
    logic        rq_ready [2];
    logic        rq_write [2];
    logic [2:0]  rq_funct3 [2];
    logic [31:0] rq_addr [2];
    logic [31:0] rq_wdata [2];
    logic        rs_valid [2];
    logic        rs_ready [2];
    logic [31:0] rs_rdata [2];
    logic        rs_error [2];
    logic [DEPTH-1:0][31:0] mchk [2];

    int tests  = 0;
    int errors = 0;

    data_memory_ctrl #(.DEPTH(DEPTH), .READ_LATENCY(1)) dut1 (
        .clk(clk), .reset(reset),
        .req_valid(rq_valid[0]), .req_ready(rq_ready[0]), .req_write(rq_write[0]),
        .req_funct3(rq_funct3[0]), .req_addr(rq_addr[0]), .req_wdata(rq_wdata[0]),
        .resp_valid(rs_valid[0]), .resp_ready(rs_ready[0]), .resp_rdata(rs_rdata[0]),
        .resp_error(rs_error[0]), .initial_values(init_vals), .memory_check(mchk[0])
    );

    data_memory_ctrl #(.DEPTH(DEPTH), .READ_LATENCY(3)) dut3 (
        .clk(clk), .reset(reset),
        .req_valid(rq_valid[1]), .req_ready(rq_ready[1]), .req_write(rq_write[1]),
        .req_funct3(rq_funct3[1]), .req_addr(rq_addr[1]), .req_wdata(rq_wdata[1]),
        .resp_valid(rs_valid[1]), .resp_ready(rs_ready[1]), .resp_rdata(rs_rdata[1]),
        .resp_error(rs_error[1]), .initial_values(init_vals), .memory_check(mchk[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Full handshake with resp_ready held high; lat counts edges from the accepting edge (inclusive).
    task automatic txn(input int d, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err, output int lat);
        @(negedge clk);
        rq_valid[d]  = 1'b1;
        rq_write[d]  = wr;
        rq_funct3[d] = f3;
        rq_addr[d]   = addr;
        rq_wdata[d]  = wdata;
        rs_ready[d]  = 1'b1;
        @(negedge clk);
        rq_valid[d] = 1'b0;
        lat = 1;
        while (!rs_valid[d] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (!rs_valid[d]) check("resp_timeout", 32'(lat), 32'(0));
        rdata = rs_rdata[d];
        err   = rs_error[d];
        @(negedge clk);
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;

    initial begin
        for (int i = 0; i < DEPTH; i++) init_vals[i] = 32'h0101_0101 * i;
        init_vals[2] = 32'h80FF_7F01;
        init_vals[4] = 32'h1111_2222;
        for (int d = 0; d < 2; d++) begin
            rq_valid[d] = 1'b0; rq_write[d] = 1'b0; rq_funct3[d] = 3'b000;
            rq_addr[d] = 32'h0; rq_wdata[d] = 32'h0; rs_ready[d] = 1'b0;
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_req_ready",  32'(rq_ready[0]), 32'd1);
        check("rst_resp_valid", 32'(rs_valid[0]), 32'd0);
        check("rst_rdata",      rs_rdata[0],      32'h0);
        check("rst_error",      32'(rs_error[0]), 32'd0);
        check("rst_mem2",       mchk[0][2],       32'h80FF_7F01);
        reset = 1'b1;

        txn(0, 1'b0, 3'b010, 32'h08, 32'h0, rd, er, lat);
        check("lw_lat1",  32'(lat), 32'd1);
        check("lw_data",  rd, 32'h80FF_7F01);
        check("lw_err",   32'(er), 32'd0);
        txn(0, 1'b0, 3'b000, 32'h0B, 32'h0, rd, er, lat);
        check("lb_0b",  rd, 32'hFFFF_FF80);
        txn(0, 1'b0, 3'b100, 32'h0B, 32'h0, rd, er, lat);
        check("lbu_0b", rd, 32'h0000_0080);
        txn(0, 1'b0, 3'b001, 32'h0A, 32'h0, rd, er, lat);
        check("lh_0a",  rd, 32'hFFFF_80FF);
        txn(0, 1'b0, 3'b101, 32'h08, 32'h0, rd, er, lat);
        check("lhu_08", rd, 32'h0000_7F01);

        txn(0, 1'b1, 3'b000, 32'h09, 32'hAAAA_AA55, rd, er, lat);
        check("sb_rdata", rd, 32'h0);
        check("sb_err",   32'(er), 32'd0);
        check("sb_mem2",  mchk[0][2], 32'h80FF_5501);
        txn(0, 1'b0, 3'b010, 32'h08, 32'h0, rd, er, lat);
        check("lw_after_sb", rd, 32'h80FF_5501);
        txn(0, 1'b1, 3'b001, 32'h0A, 32'h0000_1234, rd, er, lat);
        check("sh_mem2", mchk[0][2], 32'h1234_5501);

        txn(0, 1'b0, 3'b010, 32'h06, 32'h0, rd, er, lat);
        check("lw_mis_err",  32'(er), 32'd1);
        check("lw_mis_data", rd, 32'h0);
        txn(0, 1'b1, 3'b001, 32'h03, 32'hFFFF_FFFF, rd, er, lat);
        check("sh_mis_err",  32'(er), 32'd1);
        check("sh_mis_mem0", mchk[0][0], 32'h0);
        txn(0, 1'b0, 3'b010, 32'h80, 32'h0, rd, er, lat);
        check("lw_range_err",  32'(er), 32'd1);
        check("lw_range_data", rd, 32'h0);
        txn(0, 1'b0, 3'b011, 32'h08, 32'h0, rd, er, lat);
        check("ld_f3_err",  32'(er), 32'd1);
        check("ld_f3_data", rd, 32'h0);
        txn(0, 1'b1, 3'b100, 32'h08, 32'hFFFF_FFFF, rd, er, lat);
        check("st_f3_err",  32'(er), 32'd1);
        check("st_f3_mem2", mchk[0][2], 32'h1234_5501);

        // Latency 3 with delayed consumer and a stray request during WAIT.
        @(negedge clk);
        rq_valid[1] = 1'b1; rq_write[1] = 1'b0; rq_funct3[1] = 3'b010;
        rq_addr[1] = 32'h08; rs_ready[1] = 1'b0;
        @(negedge clk);
        check("rl3_e1_valid", 32'(rs_valid[1]), 32'd0);
        check("rl3_e1_ready", 32'(rq_ready[1]), 32'd0);
        rq_addr[1] = 32'h10;
        @(negedge clk);
        check("rl3_e2_valid", 32'(rs_valid[1]), 32'd0);
        rq_valid[1] = 1'b0;
        @(negedge clk);
        check("rl3_e3_valid", 32'(rs_valid[1]), 32'd1);
        check("rl3_data",     rs_rdata[1], 32'h80FF_7F01);
        @(negedge clk);
        check("rl3_hold1_valid", 32'(rs_valid[1]), 32'd1);
        check("rl3_hold1_data",  rs_rdata[1], 32'h80FF_7F01);
        check("rl3_hold1_ready", 32'(rq_ready[1]), 32'd0);
        @(negedge clk);
        check("rl3_hold2_data",  rs_rdata[1], 32'h80FF_7F01);
        rs_ready[1] = 1'b1;
        @(negedge clk);
        check("rl3_done_valid", 32'(rs_valid[1]), 32'd0);
        check("rl3_done_ready", 32'(rq_ready[1]), 32'd1);
        repeat (4) @(negedge clk);
        check("rl3_no_stray", 32'(rs_valid[1]), 32'd0);

        // Store abandoned by reset while waiting.
        rq_valid[1] = 1'b1; rq_write[1] = 1'b1; rq_funct3[1] = 3'b010;
        rq_addr[1] = 32'h10; rq_wdata[1] = 32'hDEAD_BEEF;
        @(negedge clk);
        rq_valid[1] = 1'b0;
        check("rst_mid_inwait", 32'(rq_ready[1]), 32'd0);
        reset = 1'b0;
        #1;
        check("rst_mid_mem4",  mchk[1][4], 32'h1111_2222);
        check("rst_mid_ready", 32'(rq_ready[1]), 32'd1);
        check("rst_mid_valid", 32'(rs_valid[1]), 32'd0);
        check("rst_mid_mem2_dut1", mchk[0][2], 32'h80FF_7F01);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check("rst_after_mem4",  mchk[1][4], 32'h1111_2222);
        check("rst_after_valid", 32'(rs_valid[1]), 32'd0);

        txn(1, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, rd, er, lat);
        check("rl3_sw_lat",  32'(lat), 32'd3);
        check("rl3_sw_mem4", mchk[1][4], 32'hDEAD_BEEF);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
